free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 28 ++
 rtl/free_list_popcount_prefix.sv | 21 ++
 rtl/free_list.sv | 102 ++++++++++
 tb/tb_free_list.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared rename types: micro-op as seen at retire, size macros and preg index widths.
`ifndef PRF_INT_SIZE
`define PRF_INT_SIZE 64
`endif
`ifndef ARF_INT_SIZE
`define ARF_INT_SIZE 32
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package free_list_pkg;
  localparam int PRF_INT_SIZE = `PRF_INT_SIZE;
  localparam int ARF_INT_SIZE = `ARF_INT_SIZE;
  localparam int RENAME_W     = `RENAME_WIDTH;
  localparam int COMMIT_W     = `COMMIT_WIDTH;
  localparam int PREG_W       = $clog2(PRF_INT_SIZE);
  localparam int AREG_W       = $clog2(ARF_INT_SIZE);

  typedef struct packed {
    logic              valid;
    logic [AREG_W-1:0] rd_arf_int_index;
    logic [PREG_W-1:0] rd_prf_int_index_prev;
  } micro_op_t;
endpackage

// File: rtl/free_list_popcount_prefix.sv
// Exclusive prefix popcount: prefix_o[i] = number of set bits below slot i.
module popcount_prefix #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]          bits_i,
  output logic [W-1:0][CW-1:0]  prefix_o,
  output logic [CW-1:0]         total_o
);
  logic [CW-1:0] acc;

  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < W; i++) begin
      prefix_o[i] = acc;
      acc         = acc + CW'(bits_i[i]);
    end
    total_o = acc;
  end
endmodule

// File: rtl/free_list.sv
// Circular free list of integer pregs with speculative/commit heads and recovery.
// Optional FREE_LIST_CHECK_EN adds a sticky error output for overflow / preg-0 frees.
module free_list
  import free_list_pkg::*;
#(
  parameter int PRF_SIZE     = PRF_INT_SIZE,
  parameter int ARF_SIZE     = ARF_INT_SIZE,
  parameter int RENAME_WIDTH = RENAME_W,
  parameter int COMMIT_WIDTH = COMMIT_W,
  parameter int IW           = $clog2(PRF_SIZE)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [RENAME_WIDTH-1:0]            alloc_req,
  output logic [RENAME_WIDTH-1:0][IW-1:0]    alloc_preg,
  output logic                               allocatable,
  input  micro_op_t [COMMIT_WIDTH-1:0]       uop_retire,
  input  logic                               recover,
  output logic [IW:0]                        free_count
`ifdef FREE_LIST_CHECK_EN
  , output logic                             error
`endif
);
  localparam int PW  = IW + 1;  // extra wrap bit distinguishes full from empty
  localparam int ACW = $clog2(RENAME_WIDTH + 1);
  localparam int FCW = $clog2(COMMIT_WIDTH + 1);

  logic [PRF_SIZE-1:0][IW-1:0] mem_q, mem_d;
  logic [PW-1:0] spec_head_q, spec_head_d, commit_head_q, commit_head_d, tail_q, tail_d;
  logic [PW-1:0] free_count_q;

  logic [COMMIT_WIDTH-1:0]          free_v;
  logic [RENAME_WIDTH-1:0][ACW-1:0] apre;
  logic [ACW-1:0]                   atot;
  logic [COMMIT_WIDTH-1:0][FCW-1:0] fpre;
  logic [FCW-1:0]                   ftot;

  always_comb
    for (int i = 0; i < COMMIT_WIDTH; i++)
      free_v[i] = uop_retire[i].valid && (uop_retire[i].rd_arf_int_index != '0);

  popcount_prefix #(.W(RENAME_WIDTH), .CW(ACW)) u_apc (
    .bits_i(alloc_req), .prefix_o(apre), .total_o(atot));
  popcount_prefix #(.W(COMMIT_WIDTH), .CW(FCW)) u_fpc (
    .bits_i(free_v), .prefix_o(fpre), .total_o(ftot));

  // Free count is registered, so frees this cycle cannot feed this cycle's grant.
  assign allocatable = !recover && (free_count_q >= PW'(atot));
  assign free_count  = free_count_q;

  always_comb
    for (int i = 0; i < RENAME_WIDTH; i++)
      alloc_preg[i] = (allocatable && alloc_req[i])
                    ? mem_q[IW'(spec_head_q + PW'(apre[i]))] : '0;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (free_v[i])
        mem_d[IW'(tail_q + PW'(fpre[i]))] = IW'(uop_retire[i].rd_prf_int_index_prev);
    tail_d        = tail_q + PW'(ftot);
    commit_head_d = commit_head_q + PW'(ftot);
    spec_head_d   = recover ? commit_head_d
                            : spec_head_q + (allocatable ? PW'(atot) : '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PRF_SIZE; k++)
        mem_q[k] <= (k < PRF_SIZE - ARF_SIZE) ? IW'(ARF_SIZE + k) : '0;
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PW'(PRF_SIZE - ARF_SIZE);
      free_count_q  <= PW'(PRF_SIZE - ARF_SIZE);
    end else begin
      mem_q         <= mem_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= tail_d - spec_head_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic          error_q;
  logic [PW:0]   fc_after;
  logic          zero_free;

  assign fc_after = {1'b0, free_count_q} + (PW+1)'(ftot);
  always_comb begin
    zero_free = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (free_v[i] && uop_retire[i].rd_prf_int_index_prev == '0) zero_free = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) error_q <= 1'b0;
    else if (zero_free || fc_after > (PW+1)'(PRF_SIZE)) error_q <= 1'b1;
  end
  assign error = error_q;
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: alloc patterns, drain/refill, recover, wrap, optional check.
module tb_free_list;
  import free_list_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [3:0]           alloc_req;
  logic [3:0][5:0]      alloc_preg;
  logic                 allocatable;
  micro_op_t [3:0]      uop_retire;
  logic                 recover;
  logic [6:0]           free_count;
`ifdef FREE_LIST_CHECK_EN
  logic                 error;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] last;

  free_list dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_preg(alloc_preg),
    .allocatable(allocatable), .uop_retire(uop_retire), .recover(recover),
    .free_count(free_count)
`ifdef FREE_LIST_CHECK_EN
    , .error(error)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req  = '0;
    uop_retire = '0;
    recover    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    do_reset();
    chk("reset_fc", free_count, 32);
    chk("reset_alloc_ok", allocatable, 1);

    // four grants from the reset image
    alloc_req = 4'b1111; #1;
    chk("a1111_ok", allocatable, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("a1111_s%0d", i), alloc_preg[i], 32 + i);
    tick(); alloc_req = '0;
    chk("a1111_fc", free_count, 28);

    // sparse request: idle slots read zero and consume nothing
    do_reset();
    alloc_req = 4'b1010; #1;
    chk("a1010_s0", alloc_preg[0], 0);
    chk("a1010_s1", alloc_preg[1], 32);
    chk("a1010_s2", alloc_preg[2], 0);
    chk("a1010_s3", alloc_preg[3], 33);
    tick(); alloc_req = '0;
    chk("a1010_fc", free_count, 30);

    // drain to empty, free one, it becomes allocatable only next cycle
    do_reset();
    alloc_req = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    alloc_req = '0;
    chk("drain_fc", free_count, 0);
    alloc_req  = 4'b0001;
    uop_retire[0] = '{valid: 1'b1, rd_arf_int_index: 5'd1, rd_prf_int_index_prev: 6'd5};
    #1;
    chk("empty_ok", allocatable, 0);
    chk("empty_s0", alloc_preg[0], 0);
    tick(); uop_retire = '0; #1;
    chk("refill_fc", free_count, 1);
    chk("refill_ok", allocatable, 1);
    chk("refill_s0", alloc_preg[0], 5);
    tick(); alloc_req = '0;
    chk("refill_fc0", free_count, 0);

    // 8 allocated, 3 freeing retires (slot 3 targets x0, not freeing), then recover
    do_reset();
    alloc_req = 4'b1111; tick(); tick(); alloc_req = '0;
    uop_retire[0] = '{valid: 1'b1, rd_arf_int_index: 5'd4, rd_prf_int_index_prev: 6'd1};
    uop_retire[1] = '{valid: 1'b1, rd_arf_int_index: 5'd5, rd_prf_int_index_prev: 6'd2};
    uop_retire[2] = '{valid: 1'b1, rd_arf_int_index: 5'd6, rd_prf_int_index_prev: 6'd3};
    uop_retire[3] = '{valid: 1'b1, rd_arf_int_index: 5'd0, rd_prf_int_index_prev: 6'd9};
    tick(); uop_retire = '0;
    chk("pre_rec_fc", free_count, 27);
    recover = 1'b1; alloc_req = 4'b1111; #1;
    chk("rec_ok", allocatable, 0);
    chk("rec_pregs", alloc_preg, 0);
    tick(); recover = 1'b0; alloc_req = '0;
    chk("rec_fc", free_count, 32);
    alloc_req = 4'b0001; #1;
    chk("rec_head", alloc_preg[0], 35);
    tick(); alloc_req = '0;

    // wrap: alloc one per cycle while freeing the previous grant
    do_reset();
    for (int j = 0; j < 70; j++) begin
      alloc_req = 4'b0001;
      uop_retire = '0;
      if (j > 0)
        uop_retire[0] = '{valid: 1'b1, rd_arf_int_index: 5'd7, rd_prf_int_index_prev: last};
      #1;
      chk($sformatf("wrap_%0d", j), alloc_preg[0], 32 + (j % 32));
      last = 6'(32 + (j % 32));
      tick();
    end
    alloc_req = '0;
    uop_retire[0] = '{valid: 1'b1, rd_arf_int_index: 5'd7, rd_prf_int_index_prev: last};
    tick(); uop_retire = '0;
    chk("wrap_fc", free_count, 32);

`ifdef FREE_LIST_CHECK_EN
    do_reset();
    chk("err_rst", error, 0);
    uop_retire[0] = '{valid: 1'b1, rd_arf_int_index: 5'd3, rd_prf_int_index_prev: 6'd0};
    tick(); uop_retire = '0;
    chk("err_set", error, 1);
    tick(); tick();
    chk("err_hold", error, 1);
    do_reset();
    chk("err_clr", error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
